// File: rtl/relu_matvec_bwd.sv
// rtl/relu_matvec_bwd.sv - ReLU-masked transposed mat-vec backward pass, one MAC per cycle.
// Optional saturating arithmetic: define RELU_MATVEC_BWD_SAT_EN.
module relu_matvec_bwd #(
  parameter int N  = 16,
  parameter int DW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic signed [DW-1:0] w       [N][N],
  input  logic signed [DW-1:0] delta   [N],
  input  logic signed [DW-1:0] fwd_out [N],
  output logic                 busy,
  output logic                 done,
  output logic signed [DW-1:0] grad    [N]
);

  localparam int LW = $clog2(N);
`ifdef RELU_MATVEC_BWD_SAT_EN
  localparam int AW = 2*DW + LW;
`else
  localparam int AW = DW;
`endif

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

  state_t               state;
  logic signed [DW-1:0] md [N];
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] acc_next;
  logic signed [AW-1:0] prod_ext;
  logic signed [DW-1:0] res;
  logic signed [DW-1:0] wij;
  logic signed [DW-1:0] mdi;
  logic [LW-1:0]        i;
  logic [LW-1:0]        j;

  assign wij = w[i][j];
  assign mdi = md[i];

`ifdef RELU_MATVEC_BWD_SAT_EN
  localparam logic signed [AW-1:0] MAXV = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  logic signed [2*DW-1:0] wx, mx, prod_full;

  assign wx        = {{DW{wij[DW-1]}}, wij};
  assign mx        = {{DW{mdi[DW-1]}}, mdi};
  assign prod_full = wx * mx;
  assign prod_ext  = {{LW{prod_full[2*DW-1]}}, prod_full};
  assign acc_next  = acc + prod_ext;

  always_comb begin
    res = acc_next[DW-1:0];
    if (acc_next > MAXV)      res = MAXV[DW-1:0];
    else if (acc_next < MINV) res = MINV[DW-1:0];
  end
`else
  // Product truncated to DW bits; accumulator wraps like the forward layer.
  assign prod_ext = wij * mdi;
  assign acc_next = acc + prod_ext;
  assign res      = acc_next;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      acc   <= '0;
      i     <= '0;
      j     <= '0;
      for (int k = 0; k < N; k++) begin
        md[k]   <= '0;
        grad[k] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            // Zero and negative forward outputs both block the gradient.
            for (int k = 0; k < N; k++)
              md[k] <= (!fwd_out[k][DW-1] && (fwd_out[k] != '0)) ? delta[k] : '0;
            acc   <= '0;
            i     <= '0;
            j     <= '0;
            busy  <= 1'b1;
            state <= S_MAC;
          end
        end
        S_MAC: begin
          if (i == LW'(N-1)) begin
            grad[j] <= res;
            acc     <= '0;
            i       <= '0;
            j       <= j + 1'b1;
            if (j == LW'(N-1)) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end
          end else begin
            acc <= acc_next;
            i   <= i + 1'b1;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_relu_matvec_bwd.sv
// tb/tb_relu_matvec_bwd.sv - scoreboard bench for relu_matvec_bwd against an arithmetic reference.
module tb_relu_matvec_bwd;
  localparam int N  = 16;
  localparam int DW = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic signed [DW-1:0] w       [N][N];
  logic signed [DW-1:0] delta   [N];
  logic signed [DW-1:0] fwd_out [N];
  logic                 busy;
  logic                 done;
  logic signed [DW-1:0] grad    [N];

  relu_matvec_bwd #(.N(N), .DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .w(w), .delta(delta),
    .fwd_out(fwd_out), .busy(busy), .done(done), .grad(grad)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  logic [N*DW-1:0] exp_q [$];
  int              expc_q[$];
  logic [N*DW-1:0] last_vec = '0;

  task automatic check(input string name, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic check_grad(input string name, input logic [N*DW-1:0] ev);
    int bad;
    logic signed [DW-1:0] e;
    bad = -1;
    for (int k = N-1; k >= 0; k--) if (grad[k] != ev[k*DW +: DW]) bad = k;
    tests++;
    if (bad >= 0) begin
      fails++;
      e = ev[bad*DW +: DW];
      $display("FAIL %s: grad[%0d] got %0d, expected %0d", name, bad, grad[bad], e);
    end
  endtask

  // Reference: dot product of each weight column with the masked gradient.
  function automatic logic [N*DW-1:0] model();
    logic [N*DW-1:0] v;
    longint s;
    logic signed [DW-1:0] r;
    for (int c = 0; c < N; c++) begin
      s = 0;
      for (int r_i = 0; r_i < N; r_i++)
        if (fwd_out[r_i] > 0) s += longint'(w[r_i][c]) * longint'(delta[r_i]);
`ifdef RELU_MATVEC_BWD_SAT_EN
      if (s > 32767) s = 32767;
      else if (s < -32768) s = -32768;
`endif
      r = s[DW-1:0];
      v[c*DW +: DW] = r;
    end
    return v;
  endfunction

  logic [N*DW-1:0] mon_ev;
  int              mon_ec;
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got pulse at cycle %0d, expected none", cyc);
      end else begin
        mon_ev = exp_q.pop_front();
        mon_ec = expc_q.pop_front();
        check("done_cycle", cyc, mon_ec);
        check("busy_low_at_done", busy, 0);
        check_grad("grad_result", mon_ev);
      end
    end
  end

  task automatic go();
    last_vec = model();
    exp_q.push_back(last_vec);
    expc_q.push_back(cyc + N*N + 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no done after %0d cycles, expected done", t);
      exp_q.delete();
      expc_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic rand_inputs();
    logic [31:0] r;
    for (int a = 0; a < N; a++) begin
      for (int b = 0; b < N; b++) begin
        r = $urandom;
        w[a][b] = r[DW-1:0];
      end
      r = $urandom;
      delta[a] = r[DW-1:0];
      case ($urandom_range(0, 2))
        0:       fwd_out[a] = '0;
        1:       fwd_out[a] = DW'($urandom_range(1, 1000));
        default: fwd_out[a] = -DW'($urandom_range(1, 1000));
      endcase
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check_grad({tag, "_grad"}, '0);
  endtask

  int s0;
  initial begin
    for (int a = 0; a < N; a++) begin
      for (int b = 0; b < N; b++) w[a][b] = '0;
      delta[a] = '0;
      fwd_out[a] = '0;
    end
    @(negedge clk);
    @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;
    @(negedge clk);

    // Transpose orientation
    for (int b = 0; b < N; b++) w[0][b] = DW'(b);
    delta[0] = 16'sd3;
    for (int a = 0; a < N; a++) fwd_out[a] = 16'sd1;
    go();
    wait_done();

    // ReLU mask with identity weights
    for (int a = 0; a < N; a++) begin
      for (int b = 0; b < N; b++) w[a][b] = (a == b) ? 16'sd1 : 16'sd0;
      delta[a] = DW'(a + 1);
      fwd_out[a] = (a % 2 == 0) ? 16'sd0 : 16'sd5;
    end
    go();
    wait_done();

    // Overflow, positive then negative
    for (int a = 0; a < N; a++) begin
      for (int b = 0; b < N; b++) w[a][b] = 16'sd256;
      delta[a] = 16'sd256;
      fwd_out[a] = 16'sd1;
    end
    go();
    wait_done();
    for (int a = 0; a < N; a++) delta[a] = -16'sd256;
    go();
    wait_done();

    // Handshake: starts in busy and in DONE are ignored
    rand_inputs();
    s0 = cyc;
    begin
      logic [N*DW-1:0] prev;
      logic [N*DW-1:0] cur;
      prev = last_vec;
      go();
      cur = last_vec;
      wait_until(s0 + 5);
      rand_inputs_delta_only();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_until(s0 + N + 1);
      check("partial_col0", grad[0], $signed(cur[DW-1:0]));
      check("partial_hold_last", grad[N-1], $signed(prev[(N-1)*DW +: DW]));
    end
    wait_until(s0 + N*N + 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rand_inputs();
    go();
    wait_done();

    // Reset mid-operation
    rand_inputs();
    s0 = cyc;
    go();
    wait_until(s0 + 100);
    rst = 1'b1;
    #1;
    check_reset_state("midreset");
    exp_q.delete();
    expc_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rand_inputs();
    go();
    wait_done();

    // Random back-to-back vectors
    for (int t = 0; t < 6; t++) begin
      rand_inputs();
      go();
      wait_done();
    end

    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  task automatic rand_inputs_delta_only();
    logic [31:0] r;
    for (int a = 0; a < N; a++) begin
      r = $urandom;
      delta[a] = r[DW-1:0];
      fwd_out[a] = 16'sd7;
    end
  endtask

endmodule
